// File: rtl/sensor_pkg.sv
// sensor_pkg: shared types and elaboration-time helpers for the frame sequencer.
//   state_e    - sequencer states
//   phase_e    - phase to enter after the current GAP cycle
//   beat_count - output beats per frame
//   phase_width - width of the phase down-counter
package sensor_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ERASE,
      EXPOSE,
      CONVERT,
      RD_RST,
      READ,
      GAP
   } state_e;

   // Where GAP goes next. PH_END marks the gap that closes a frame.
   typedef enum logic [1:0] {
      PH_EXPOSE,
      PH_CONVERT,
      PH_RD_RST,
      PH_END
   } phase_e;

   function automatic int beat_count(input int width, input int height, input int pix_per_beat);
      return (width * height) / pix_per_beat;
   endfunction

   function automatic int phase_width(input int expose_w, input int bit_depth, input int erase_w);
      int w;
      w = expose_w;
      if (bit_depth > w) w = bit_depth;
      if (erase_w > w) w = erase_w;
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/sensor_sequencer_phase_timer.sv
// phase_timer: loadable down-counter that times the ERASE, EXPOSE and CONVERT
// phases. Loading value D-1 makes done rise D-1 cycles later, so the owning
// state lasts exactly D cycles when it leaves on done.
//   clk        in  clock
//   reset      in  synchronous active-high reset
//   load       in  load load_value this cycle
//   load_value in  CW  starting count
//   done       out count has reached zero
module phase_timer #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   output logic          done
);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - CW'(1);
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/sensor_sequencer.sv
// sensor_sequencer: frame sequencer for the pixel sensor array.
// Runs ERASE -> EXPOSE -> CONVERT -> RD_RST -> READ with a one-cycle GAP
// between phases (none between RD_RST and READ), in single-shot or
// continuous mode. Readout is paced by out_ready.
// Ports:
//   clk, reset (sync, active-high)
//   start, continuous, stop, expose_cycles  - control from system controller
//   out_ready                               - downstream beat acceptance
//   power_enable, write_enable, counter_reset, erase, expose, convert,
//   read_reset, read                        - array control lines
//   busy, frame_done                        - status
//   frame_count [15:0]                      - only with SENSOR_SEQUENCER_FRAME_COUNT_EN
// Optional macro: SENSOR_SEQUENCER_FRAME_COUNT_EN adds the frame counter.
module sensor_sequencer
   import sensor_pkg::*;
#(
   parameter int WIDTH                  = 8,
   parameter int HEIGHT                 = 2,
   parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
   parameter int BIT_DEPTH              = 8,
   parameter int C_ERASE                = 5,
   parameter int EXPOSE_W               = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                continuous,
   input  logic                stop,
   input  logic [EXPOSE_W-1:0] expose_cycles,
   input  logic                out_ready,
   output logic                power_enable,
   output logic                write_enable,
   output logic                counter_reset,
   output logic                erase,
   output logic                expose,
   output logic                convert,
   output logic                read_reset,
   output logic                read,
   output logic                busy,
   output logic                frame_done
`ifdef SENSOR_SEQUENCER_FRAME_COUNT_EN
   ,
   output logic [15:0]         frame_count
`endif
);

   localparam int N_BEATS = beat_count(WIDTH, HEIGHT, OUTPUT_BUS_PIXEL_WIDTH);
   localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS + 1) : 1;
   localparam int CW      = phase_width(EXPOSE_W, BIT_DEPTH, $clog2(C_ERASE));

   localparam logic [CW-1:0] ERASE_LOAD = CW'(C_ERASE - 1);
   localparam logic [CW-1:0] CONV_LOAD  = CW'((2 ** BIT_DEPTH) - 2);
   localparam logic [BW-1:0] LAST_BEAT  = BW'(N_BEATS - 1);

   state_e                state_reg;
   phase_e                phase_reg;
   logic [EXPOSE_W-1:0]   expose_reg;
   logic                  cont_reg;
   logic [BW-1:0]         beat_reg;

   logic power_reg, we_reg, cr_reg, erase_reg, expose_out_reg, convert_reg;
   logic read_reset_reg, read_en_reg, busy_reg, frame_done_reg;

   logic          timer_load;
   logic [CW-1:0] timer_value;
   logic [CW-1:0] expose_load;
   logic          timer_done;

   // Exposure of 0 behaves as 1 cycle, so the load value saturates at 0.
   assign expose_load = (expose_reg == '0) ? '0 : CW'(expose_reg - EXPOSE_W'(1));

   // The timer is loaded on the same edge that enters a timed phase.
   always_comb begin
      timer_load  = 1'b0;
      timer_value = '0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               timer_load  = 1'b1;
               timer_value = ERASE_LOAD;
            end
         end
         GAP: begin
            case (phase_reg)
               PH_EXPOSE: begin
                  timer_load  = 1'b1;
                  timer_value = expose_load;
               end
               PH_CONVERT: begin
                  timer_load  = 1'b1;
                  timer_value = CONV_LOAD;
               end
               PH_END: begin
                  if (cont_reg && !stop) begin
                     timer_load  = 1'b1;
                     timer_value = ERASE_LOAD;
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   phase_timer #(
      .CW(CW)
   ) u_phase_timer (
      .clk       (clk),
      .reset     (reset),
      .load      (timer_load),
      .load_value(timer_value),
      .done      (timer_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         phase_reg      <= PH_EXPOSE;
         expose_reg     <= '0;
         cont_reg       <= 1'b0;
         beat_reg       <= '0;
         power_reg      <= 1'b0;
         we_reg         <= 1'b0;
         cr_reg         <= 1'b0;
         erase_reg      <= 1'b0;
         expose_out_reg <= 1'b0;
         convert_reg    <= 1'b0;
         read_reset_reg <= 1'b0;
         read_en_reg    <= 1'b0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  expose_reg <= expose_cycles;
                  // stop alongside start turns the request into a single frame
                  cont_reg   <= continuous & ~stop;
                  state_reg  <= ERASE;
                  erase_reg  <= 1'b1;
                  cr_reg     <= 1'b1;
                  busy_reg   <= 1'b1;
               end
            end
            ERASE: begin
               if (timer_done) begin
                  state_reg <= GAP;
                  phase_reg <= PH_EXPOSE;
                  erase_reg <= 1'b0;
                  cr_reg    <= 1'b0;
               end
            end
            EXPOSE: begin
               if (timer_done) begin
                  state_reg      <= GAP;
                  phase_reg      <= PH_CONVERT;
                  we_reg         <= 1'b0;
                  expose_out_reg <= 1'b0;
               end
            end
            CONVERT: begin
               if (timer_done) begin
                  state_reg   <= GAP;
                  phase_reg   <= PH_RD_RST;
                  we_reg      <= 1'b0;
                  convert_reg <= 1'b0;
               end
            end
            RD_RST: begin
               state_reg      <= READ;
               read_reset_reg <= 1'b0;
               read_en_reg    <= 1'b1;
               beat_reg       <= '0;
            end
            READ: begin
               if (out_ready) begin
                  if (beat_reg == LAST_BEAT) begin
                     state_reg      <= GAP;
                     phase_reg      <= PH_END;
                     read_en_reg    <= 1'b0;
                     frame_done_reg <= 1'b1;
                     beat_reg       <= '0;
                  end else begin
                     beat_reg <= beat_reg + BW'(1);
                  end
               end
            end
            GAP: begin
               // power_reg is left alone on entry to GAP, so it holds here.
               case (phase_reg)
                  PH_EXPOSE: begin
                     state_reg      <= EXPOSE;
                     power_reg      <= 1'b1;
                     we_reg         <= 1'b1;
                     expose_out_reg <= 1'b1;
                  end
                  PH_CONVERT: begin
                     state_reg   <= CONVERT;
                     power_reg   <= 1'b1;
                     we_reg      <= 1'b1;
                     convert_reg <= 1'b1;
                  end
                  PH_RD_RST: begin
                     state_reg      <= RD_RST;
                     power_reg      <= 1'b1;
                     read_reset_reg <= 1'b1;
                  end
                  PH_END: begin
                     frame_done_reg <= 1'b0;
                     power_reg      <= 1'b0;
                     if (cont_reg && !stop) begin
                        state_reg  <= ERASE;
                        expose_reg <= expose_cycles;
                        erase_reg  <= 1'b1;
                        cr_reg     <= 1'b1;
                     end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                     end
                  end
                  default: state_reg <= IDLE;
               endcase
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef SENSOR_SEQUENCER_FRAME_COUNT_EN
   logic [15:0] frame_count_reg;

   // Advances on the same edge that raises frame_done; wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count_reg <= '0;
      end else if (state_reg == READ && out_ready && beat_reg == LAST_BEAT) begin
         frame_count_reg <= frame_count_reg + 16'd1;
      end
   end

   assign frame_count = frame_count_reg;
`else
   // Frame counter not built.
`endif

   assign power_enable  = power_reg;
   assign write_enable  = we_reg;
   assign counter_reset = cr_reg;
   assign erase         = erase_reg;
   assign expose        = expose_out_reg;
   assign convert       = convert_reg;
   assign read_reset    = read_reset_reg;
   // read_en_reg marks the READ state; a beat moves only when downstream is ready.
   assign read          = read_en_reg & out_ready;
   assign busy          = busy_reg;
   assign frame_done    = frame_done_reg;

endmodule

// File: tb/tb_sensor_sequencer.sv
// Testbench for sensor_sequencer: frame timeline reference model built from
// phase lengths, randomized exposure/backpressure/continuous runs.
module tb_sensor_sequencer;

   localparam int WIDTH    = 8;
   localparam int HEIGHT   = 2;
   localparam int OPW      = 2;
   localparam int BIT_DEPTH = 8;
   localparam int C_ERASE  = 5;
   localparam int EXPOSE_W = 16;
   localparam int N_BEATS  = WIDTH * HEIGHT / OPW;
   localparam int CONV_LEN = (2 ** BIT_DEPTH) - 1;

   // Timeline segment kinds of one frame.
   localparam int S_ERASE   = 0;
   localparam int S_GAP_OFF = 1;
   localparam int S_EXPOSE  = 2;
   localparam int S_GAP_ON  = 3;
   localparam int S_CONVERT = 4;
   localparam int S_RDRST   = 5;
   localparam int S_READ    = 6;
   localparam int S_DONE    = 7;

   logic clk = 1'b0;
   logic reset, start, continuous, stop, out_ready;
   logic [EXPOSE_W-1:0] expose_cycles;
   logic power_enable, write_enable, counter_reset, erase, expose, convert;
   logic read_reset, read, busy, frame_done;
`ifdef SENSOR_SEQUENCER_FRAME_COUNT_EN
   logic [15:0] frame_count;
`endif

   int vectors = 0;
   int miscompares = 0;
   int frames_since_reset = 0;

   always #5 clk = ~clk;

   sensor_sequencer #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .OUTPUT_BUS_PIXEL_WIDTH(OPW),
      .BIT_DEPTH(BIT_DEPTH), .C_ERASE(C_ERASE), .EXPOSE_W(EXPOSE_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .stop(stop), .expose_cycles(expose_cycles), .out_ready(out_ready),
      .power_enable(power_enable), .write_enable(write_enable),
      .counter_reset(counter_reset), .erase(erase), .expose(expose),
      .convert(convert), .read_reset(read_reset), .read(read),
      .busy(busy), .frame_done(frame_done)
`ifdef SENSOR_SEQUENCER_FRAME_COUNT_EN
      , .frame_count(frame_count)
`endif
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // {power, we, counter_reset, erase, expose, convert, read_reset, read, busy, frame_done}
   function automatic logic [9:0] obs();
      return {power_enable, write_enable, counter_reset, erase, expose, convert,
              read_reset, read, busy, frame_done};
   endfunction

   function automatic logic [9:0] seg_vec(input int seg, input logic rd);
      case (seg)
         S_ERASE:   return 10'b0011000010;
         S_GAP_OFF: return 10'b0000000010;
         S_EXPOSE:  return 10'b1100100010;
         S_GAP_ON:  return 10'b1000000010;
         S_CONVERT: return 10'b1100010010;
         S_RDRST:   return 10'b1000001010;
         S_READ:    return 10'b1000000010 | {7'b0, rd, 2'b0};
         S_DONE:    return 10'b1000000011;
         default:   return 10'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise start for one cycle in IDLE; returns in the first ERASE cycle.
   task automatic launch(input int e_val, input logic cont, input logic stp);
      expose_cycles = EXPOSE_W'(e_val);
      continuous = cont;
      stop = stp;
      start = 1'b1;
      tick();
      start = 1'b0;
      continuous = 1'(($urandom));
   endtask

   // Walk one frame's timeline from its first ERASE cycle through the
   // frame_done cycle. ready_mode: 0 always ready, 1 stall window, 2 random.
   task automatic run_frame(input int e_val, input int ready_mode, input int stall_at,
                            input int stall_len, input bit start_in_conv,
                            input bit stop_in_conv, input bit chg_expose,
                            input int new_expose);
      int lens[7];
      int segs[7];
      int beats;
      int k;
      logic rdy;
      lens[0] = C_ERASE;                  segs[0] = S_ERASE;
      lens[1] = 1;                        segs[1] = S_GAP_OFF;
      lens[2] = (e_val == 0) ? 1 : e_val; segs[2] = S_EXPOSE;
      lens[3] = 1;                        segs[3] = S_GAP_ON;
      lens[4] = CONV_LEN;                 segs[4] = S_CONVERT;
      lens[5] = 1;                        segs[5] = S_GAP_ON;
      lens[6] = 1;                        segs[6] = S_RDRST;
      for (int s = 0; s < 7; s++) begin
         for (int j = 0; j < lens[s]; j++) begin
            out_ready = 1'($urandom);
            start = (segs[s] == S_CONVERT && start_in_conv && j == 40);
            if (segs[s] == S_CONVERT && stop_in_conv && j == 100) stop = 1'b1;
            if (segs[s] == S_CONVERT && chg_expose && j == 50) expose_cycles = EXPOSE_W'(new_expose);
            @(negedge clk);
            vectors++;
            if (obs() !== seg_vec(segs[s], 1'b0)) begin
               miscompares++;
               $display("FAIL frame_phase seg=%0d cyc=%0d e=%0d got %b expected %b",
                        segs[s], j, e_val, obs(), seg_vec(segs[s], 1'b0));
            end
            tick();
         end
      end
      start = 1'b0;
      beats = 0;
      k = 0;
      while (beats < N_BEATS && k < 2000) begin
         case (ready_mode)
            0: rdy = 1'b1;
            1: rdy = !(k >= stall_at && k < stall_at + stall_len);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         out_ready = rdy;
         @(negedge clk);
         vectors++;
         if (obs() !== seg_vec(S_READ, rdy)) begin
            miscompares++;
            $display("FAIL read_phase beat=%0d cyc=%0d got %b expected %b",
                     beats, k, obs(), seg_vec(S_READ, rdy));
         end
         if (rdy) beats++;
         k++;
         tick();
      end
      if (k >= 2000) begin
         miscompares++;
         $display("FAIL read_timeout beats got %0d expected %0d", beats, N_BEATS);
      end
      out_ready = 1'($urandom);
      @(negedge clk);
      vectors++;
      if (obs() !== seg_vec(S_DONE, 1'b0)) begin
         miscompares++;
         $display("FAIL frame_done_cycle got %b expected %b", obs(), seg_vec(S_DONE, 1'b0));
      end
      frames_since_reset++;
      tick();
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0; continuous = 1'b0; stop = 1'b0; out_ready = 1'b1;
      expose_cycles = 16'd10;
      tick();
      tick();
      @(negedge clk);
      vectors++;
      if (obs() !== 10'b0) begin
         miscompares++;
         $display("FAIL reset_state got %b expected %b", obs(), 10'b0);
      end
      reset = 1'b0;
      frames_since_reset = 0;
      tick();
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         vectors++;
         if (obs() !== 10'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got %b expected %b", obs(), 10'b0);
         end
`ifdef SENSOR_SEQUENCER_FRAME_COUNT_EN
         vectors++;
         if (frame_count !== 16'd0) begin
            miscompares++;
            $display("FAIL frame_count_reset got %0d expected 0", frame_count);
         end
`endif
         tick();
      end
   endtask

   // Idle check used after every scenario; also tracks the frame counter.
   task automatic test_idle_after(input string tag, input int cycles);
      for (int n = 0; n < cycles; n++) begin
         stop = (n == 0) ? stop : 1'($urandom);
         @(negedge clk);
         vectors++;
         if (obs() !== 10'b0) begin
            miscompares++;
            $display("FAIL idle_%s got %b expected %b", tag, obs(), 10'b0);
         end
`ifdef SENSOR_SEQUENCER_FRAME_COUNT_EN
         vectors++;
         if (frame_count !== 16'(frames_since_reset)) begin
            miscompares++;
            $display("FAIL frame_count_%s got %0d expected %0d", tag, frame_count, frames_since_reset);
         end
`endif
         tick();
      end
      stop = 1'b0;
   endtask

   task automatic test_single_shot();
      launch(10, 1'b0, 1'b0);
      run_frame(10, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      test_idle_after("single", 3);
   endtask

   task automatic test_backpressure();
      launch(10, 1'b0, 1'b0);
      run_frame(10, 1, 3, 20, 1'b0, 1'b0, 1'b0, 0);
      test_idle_after("backpressure", 2);
   endtask

   task automatic test_continuous_stop();
      launch(10, 1'b1, 1'b0);
      run_frame(10, 0, 0, 0, 1'b0, 1'b0, 1'b1, 3);
      run_frame(3, 0, 0, 0, 1'b0, 1'b1, 1'b0, 0);
      test_idle_after("continuous_stop", 3);
   endtask

   task automatic test_expose_zero();
      launch(0, 1'b0, 1'b0);
      run_frame(0, 2, 0, 0, 1'b1, 1'b0, 1'b0, 0);
      test_idle_after("expose_zero", 2);
   endtask

   task automatic test_start_with_stop();
      launch(7, 1'b1, 1'b1);
      stop = 1'b0;
      run_frame(7, 2, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      test_idle_after("start_stop", 3);
   endtask

   task automatic test_reset_mid_frame();
      launch(10, 1'b0, 1'b0);
      for (int n = 0; n < C_ERASE + 1 + 3; n++) tick();
      @(negedge clk);
      vectors++;
      if (expose !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_abort_expose got %b expected 1", expose);
      end
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      frames_since_reset = 0;
      test_idle_after("after_abort", 5);
      launch(5, 1'b0, 1'b0);
      run_frame(5, 2, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      test_idle_after("after_abort_frame", 2);
   endtask

   task automatic test_random_runs();
      int e;
      int nf;
      int nxt;
      for (int it = 0; it < 4; it++) begin
         e = $urandom_range(0, 20);
         if ($urandom_range(0, 1) == 1) begin
            nf = $urandom_range(1, 3);
            launch(e, 1'b1, 1'b0);
            for (int f = 0; f < nf; f++) begin
               nxt = $urandom_range(0, 15);
               run_frame(e, 2, 0, 0, 1'($urandom), f == nf - 1, 1'b1, nxt);
               e = nxt;
            end
         end else begin
            launch(e, 1'b0, 1'b0);
            run_frame(e, 2, 0, 0, 1'($urandom), 1'b0, 1'b0, 0);
         end
         test_idle_after("random", 2);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0; continuous = 1'b0; stop = 1'b0; out_ready = 1'b1;
      expose_cycles = '0;
      test_reset();
      test_single_shot();
      test_backpressure();
      test_continuous_stop();
      test_expose_zero();
      test_start_with_stop();
      test_reset_mid_frame();
      test_random_runs();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
